// File: rtl/serial_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_mult_pkg
// Brief    : Shared types and defaults for the serial multiplier arbiter.
// Revision : 1.0
// ============================================================================
package serial_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREQ  = 2;

    // Requester ID width; a single requester still gets a 1-bit ID.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_mult_core.sv
`default_nettype none
// ============================================================================
// Module   : serial_mult_core
// Brief    : Iterative unsigned shift-add multiplier datapath.
//            SERIAL_MULT_EARLY_EXIT_EN ends the run once remaining b is zero.
// Revision : 1.0
// ============================================================================
module serial_mult_core
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_prod_nxt
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] w_addend;

    assign w_addend   = r_b[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
    assign o_prod_nxt = r_acc + w_addend;

    // o_done flags the step currently in progress as the final one.
`ifdef SERIAL_MULT_EARLY_EXIT_EN
    assign o_done = ((r_b >> 1) == '0);
`else
    assign o_done = (r_cnt == c_CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= o_prod_nxt;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_mult_arbiter
// Brief    : Round-robin front end sharing one serial multiplier between
//            NREQ requesters. Data-dependent latency: SERIAL_MULT_EARLY_EXIT_EN.
// Revision : 1.0
// ============================================================================
module serial_mult_arbiter
    import serial_mult_pkg::*;
#(
    parameter int NREQ  = DEFAULT_NREQ,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*WIDTH-1:0]       req_a,
    input  logic [NREQ*WIDTH-1:0]       req_b,
    input  logic                        abort,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [id_width(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]          rsp_prod,
    output logic                        aborted,
    output logic                        busy
);

    localparam int c_ID_W = id_width(NREQ);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_ID_W-1:0]   r_id;
    logic [2*WIDTH-1:0]  r_rsp_prod;
    logic                r_aborted;
    logic [c_ID_W-1:0]   w_grant;
    logic                w_found;
    logic                w_accept;
    logic                w_step;
    logic                w_done;
    logic [2*WIDTH-1:0]  w_prod_nxt;

    function automatic logic [c_ID_W-1:0] wrap_id(input int v);
        return c_ID_W'(v % NREQ);
    endfunction

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[wrap_id(int'(r_ptr) + k)]) begin
                w_found = 1'b1;
                w_grant = wrap_id(int'(r_ptr) + k);
            end
        end
    end

    assign w_accept = (r_state == IDLE) && !abort && w_found;
    assign w_step   = (r_state == RUN) && !abort;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) w_state_nxt = RUN;
            end
            RUN: begin
                if (abort)       w_state_nxt = IDLE;
                else if (w_done) w_state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (abort || rsp_ready) w_state_nxt = IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_rsp_prod <= '0;
            r_aborted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_aborted <= abort && (r_state != IDLE);
            if (w_accept) begin
                r_id  <= w_grant;
                r_ptr <= wrap_id(int'(w_grant) + 1);
            end
            // Abort wins over the final step and over a response handshake.
            if (abort && (r_state != IDLE)) begin
                r_rsp_prod <= '0;
            end else if (w_step && w_done) begin
                r_rsp_prod <= w_prod_nxt;
            end
        end
    end

    assign rsp_id   = r_id;
    assign rsp_prod = r_rsp_prod;
    assign aborted  = r_aborted;

    serial_mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .i_start    (w_accept),
        .i_step     (w_step),
        .i_a        (req_a[w_grant*WIDTH +: WIDTH]),
        .i_b        (req_b[w_grant*WIDTH +: WIDTH]),
        .o_done     (w_done),
        .o_prod_nxt (w_prod_nxt)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_mult_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serial_mult_arbiter
// Brief    : Scoreboard bench for serial_mult_arbiter (directed + random).
// Revision : 1.0
// ============================================================================
module tb_serial_mult_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;
    localparam int IDW   = 1;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  abort = 1'b0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  aborted;
    logic                  busy;

    serial_mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .abort     (abort),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .aborted   (aborted),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                 id;
        logic [2*WIDTH-1:0] prod;
        int                 hs;
        int                 k;
        bit                 seen;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc = 0;
    int              ptr = 0;
    bit              mon_en = 1'b0;
    bit              exp_aborted = 1'b0;
    logic [NREQ-1:0] hs_mask = '0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles spent in RUN: the whole width, or up to the top set bit of b.
    function automatic int model_k(input logic [WIDTH-1:0] b);
`ifdef SERIAL_MULT_EARLY_EXIT_EN
        int k = 1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) k = i + 1;
        return k;
`else
        return WIDTH;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'(1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Acceptance side: models the arbiter and pushes expected products.
    always @(negedge clock) begin
        logic [NREQ-1:0]  exp_ready;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        exp_t             e;
        int               g;
        hs_mask = req_valid & req_ready;
        if (mon_en) begin
            check("busy", busy, sb.size() != 0);
            exp_ready = '0;
            g = -1;
            if (sb.size() == 0 && !abort) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            if (g >= 0) begin
                ea = req_a[g*WIDTH +: WIDTH];
                eb = req_b[g*WIDTH +: WIDTH];
                e.id   = g;
                e.prod = (2*WIDTH)'(ea) * (2*WIDTH)'(eb);
                e.hs   = cyc;
                e.k    = model_k(eb);
                e.seen = 1'b0;
                sb.push_back(e);
                ptr = (g + 1) % NREQ;
            end
        end
    end

    // Response side: pops and compares whenever the DUT presents a product.
    always begin
        @(negedge clock);
        #1;
        if (mon_en) begin
            check("aborted", aborted, exp_aborted);
            exp_aborted = abort && (sb.size() != 0);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_valid_unexpected", rsp_valid, 0);
                end else begin
                    if (!sb[0].seen) begin
                        check("latency", cyc - sb[0].hs, sb[0].k + 1);
                        sb[0].seen = 1'b1;
                    end
                    check("rsp_prod", rsp_prod, sb[0].prod);
                    check("rsp_id", rsp_id, sb[0].id);
                end
            end
            if (abort && sb.size() != 0) begin
                void'(sb.pop_front());
            end else if (rsp_valid && rsp_ready && sb.size() != 0) begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic send(input int i, input int a, input int b);
        int t = 0;
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        do begin
            @(negedge clock);
            t++;
        end while (!(req_valid[i] && req_ready[i]) && t < 60);
        if (t >= 60) check("send_timeout", 1, 0);
        @(posedge clock);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 80) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 80) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_rsp_valid();
        int t = 0;
        while (!rsp_valid && t < 40) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 40) check("rsp_valid_timeout", 1, 0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clock);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_prod", rsp_prod, 0);
        check("reset_aborted", aborted, 0);
        check("reset_busy", busy, 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        rsp_ready = 1'b1;

        // Single multiply, then round-robin with both requesters contending.
        send(0, 3, 5);
        wait_idle();
        req_a = {NREQ{WIDTH'(2)}};
        req_b = {NREQ{WIDTH'(2)}};
        req_valid = '1;
        t = 0;
        for (int n = 0; n < 4 && t < 200; ) begin
            @(negedge clock);
            t++;
            if (|(req_valid & req_ready)) n++;
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        wait_idle();

        // Maximum operands held under backpressure.
        rsp_ready = 1'b0;
        send(0, 255, 255);
        wait_rsp_valid();
        repeat (5) @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        wait_idle();

        // Abort in the 4th RUN cycle, then a fresh request.
        send(1, 77, 201);
        repeat (3) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        wait_idle();
        send(0, 9, 10);
        wait_idle();

        // Abort coinciding with the response handshake.
        send(1, 100, 3);
        wait_rsp_valid();
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        wait_idle();

        // Randomized traffic with backpressure and sporadic aborts.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs_mask[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*WIDTH +: WIDTH] = rnd_op();
                    req_b[i*WIDTH +: WIDTH] = rnd_op();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 49) == 0);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        abort     = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        @(negedge clock);
        #2;
        check("scoreboard_drained", sb.size(), 0);

        // Asynchronous reset in the middle of a multiply.
        mon_en = 1'b0;
        send(1, 5, 5);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_rsp_valid", rsp_valid, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        req_valid = '1;
        @(negedge clock);
        check("reset_pointer_grant", req_ready, 1);
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
